// File: rtl/rf_write_arbiter.sv
// Merges pipeline writeback (A) and buffered slow-unit writeback (B) onto the single RF write
// port, keeping per-register write-after-write order and exporting a pending-write mask.
module rf_write_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_wa,
    input  logic [31:0] a_wd,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_wa,
    input  logic [31:0] b_wd,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic        RegWrite,
    output logic [31:0] pending_mask
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [PtrW:0]  FullCnt   = DEPTH[PtrW:0];
    localparam logic [SW-1:0]  StarveMax = STARVE_LIMIT[SW-1:0];

    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       ewa_q [DEPTH];
    logic [4:0]       ewa_n [DEPTH];
    logic [31:0]      ewd_q [DEPTH];
    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PtrW:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [4:0]       wa_q, wa_d;
    logic [31:0]      wd_q, wd_d;
    logic             we_q, we_d;
    logic [31:0]      mask_q, mask_d;

    logic head_present, head_live, a_req, push, pop, a_win, head_write;

    assign head_present = (count_q != '0);
    assign head_live    = head_present && live_q[head_q];
    assign a_req        = a_valid && (a_wa != 5'd0);
    assign b_ready      = (count_q != FullCnt);
    assign push         = b_valid && b_ready && (b_wa != 5'd0);

    // Slot decision; a squashed head is retired for free and does not consume the write slot.
    always_comb begin
        pop        = 1'b0;
        a_win      = 1'b0;
        head_write = 1'b0;
        a_ready    = 1'b1;
        if (head_present && !live_q[head_q]) begin
            pop   = 1'b1;
            a_win = a_req;
        end else if (head_live && (starve_q == StarveMax)) begin
            a_ready    = 1'b0;
            pop        = 1'b1;
            head_write = 1'b1;
        end else if (a_req) begin
            a_win = 1'b1;
        end else if (head_live) begin
            pop        = 1'b1;
            head_write = 1'b1;
        end
    end

    always_comb begin
        live_d  = live_q;
        ewa_n   = ewa_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (a_win) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ewa_q[i] == a_wa) live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
        end
        // A same-cycle A write to the same register is newer, so the pushed entry is born dead.
        if (push) begin
            live_d[tail_q] = !(a_win && (b_wa == a_wa));
            ewa_n[tail_q]  = b_wa;
            tail_d         = tail_q + 1'b1;
        end
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        mask_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_d[i]) mask_d[ewa_n[i]] = 1'b1;
        end

        starve_d = starve_q;
        if (head_write || (live_d == '0)) starve_d = '0;
        else if (a_win && head_live && (starve_q != StarveMax)) starve_d = starve_q + 1'b1;

        we_d = a_win || head_write;
        wa_d = wa_q;
        wd_d = wd_q;
        if (head_write) begin
            wa_d = ewa_q[head_q];
            wd_d = ewd_q[head_q];
        end else if (a_win) begin
            wa_d = a_wa;
            wd_d = a_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            mask_q   <= '0;
        end else begin
            live_q   <= live_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            mask_q   <= mask_d;
        end
    end

    // Payload storage needs no reset; the live bits qualify it.
    always_ff @(posedge clk) begin
        ewa_q <= ewa_n;
        if (push) ewd_q[tail_q] <= b_wd;
    end

    assign wa           = wa_q;
    assign wd           = wd_q;
    assign RegWrite     = we_q;
    assign pending_mask = mask_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected RF writes are queued as stimulus is driven
// and compared in order whenever RegWrite is observed.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready, RegWrite;
    logic [4:0]  a_wa, b_wa, wa;
    logic [31:0] a_wd, b_wd, wd, pending_mask;

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q [$];

    always #5 clk = ~clk;

    rf_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_wa         (a_wa),
        .a_wd         (a_wd),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_wa         (b_wa),
        .b_wd         (b_wd),
        .wa           (wa),
        .wd           (wd),
        .RegWrite     (RegWrite),
        .pending_mask (pending_mask)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [4:0] r, input logic [31:0] d);
        a_valid = v;
        a_wa    = r;
        a_wd    = d;
    endtask

    task automatic set_b(input logic v, input logic [4:0] r, input logic [31:0] d);
        b_valid = v;
        b_wa    = r;
        b_wd    = d;
    endtask

    task automatic exp_wr(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    // Every observed RF write must be the oldest outstanding expected write.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("extra_write", {27'd0, wa, wd}, 64'd0);
            end else begin
                check("wr", {27'd0, wa, wd}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        step();
        step();
        rst = 1'b0;
        check("rst_regwrite", RegWrite, 0);
        check("rst_wa", wa, 0);
        check("rst_wd", wd, 0);
        check("rst_mask", pending_mask, 0);
        check("rst_bready", b_ready, 1);
        check("rst_aready", a_ready, 1);
        step();

        // Plain port A write, then an r0 request that must be ignored.
        set_a(1'b1, 5'd5, 32'h1234_5678);
        exp_wr(5'd5, 32'h1234_5678);
        step();
        check("a5_regwrite", RegWrite, 1);
        check("a5_wa", wa, 5);
        check("a5_wd", wd, 32'h1234_5678);
        set_a(1'b1, 5'd0, 32'hDEAD_BEEF);
        #1 check("a0_ready", a_ready, 1);
        step();
        set_a(1'b0, 5'd0, 32'd0);
        check("a0_nowrite", RegWrite, 0);

        // Port B alone: mask one cycle after push, write two cycles after.
        set_b(1'b1, 5'd9, 32'hAAAA_0001);
        exp_wr(5'd9, 32'hAAAA_0001);
        step();
        set_b(1'b0, 5'd0, 32'd0);
        check("b9_mask_set", pending_mask[9], 1);
        check("b9_no_bypass", RegWrite, 0);
        step();
        check("b9_write", RegWrite, 1);
        check("b9_wa", wa, 9);
        check("b9_mask_clr", pending_mask[9], 0);

        // Starvation: r3 waits while A streams; the 4th A cycle is stalled.
        set_b(1'b1, 5'd3, 32'h0000_0033);
        step();
        set_b(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 5'(4 + (i == 0 ? 0 : i + 1)), 32'h4400_0000 + 32'(i));
            #1 check("starve_win", a_ready, 1);
            exp_wr(5'(4 + (i == 0 ? 0 : i + 1)), 32'h4400_0000 + 32'(i));
            step();
        end
        set_a(1'b1, 5'd8, 32'h0000_0088);
        #1 check("starve_block", a_ready, 0);
        exp_wr(5'd3, 32'h0000_0033);
        step();
        check("starve_wa", wa, 3);
        #1 check("starve_resume", a_ready, 1);
        exp_wr(5'd8, 32'h0000_0088);
        step();
        set_a(1'b0, 5'd0, 32'd0);
        check("resume_wa", wa, 8);

        // WAW squash: A to r10 kills the queued B write to r10.
        set_b(1'b1, 5'd10, 32'd1);
        step();
        set_b(1'b0, 5'd0, 32'd0);
        check("sq_mask_set", pending_mask[10], 1);
        set_a(1'b1, 5'd10, 32'd2);
        exp_wr(5'd10, 32'd2);
        step();
        set_a(1'b0, 5'd0, 32'd0);
        check("sq_mask_clr", pending_mask[10], 0);
        check("sq_wd", wd, 2);
        step();
        check("sq_pop_nowrite", RegWrite, 0);

        // Fill to DEPTH under A traffic, hold a request while full, then drain across the wrap.
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 5'(20 + i), 32'hA000_0000 + 32'(i));
            set_b(1'b1, 5'(12 + i), 32'hB000_0000 + 32'(i));
            #1 check("fill_bready", b_ready, 1);
            exp_wr(5'(20 + i), 32'hA000_0000 + 32'(i));
            step();
        end
        check("full_mask", pending_mask, 32'h0000_F000);
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b1, 5'd11, 32'hB000_0011);
        #1 check("full_bready", b_ready, 0);
        for (int i = 0; i < 4; i++) exp_wr(5'(12 + i), 32'hB000_0000 + 32'(i));
        exp_wr(5'd11, 32'hB000_0011);
        step();
        check("unfull_bready", b_ready, 1);
        step();
        set_b(1'b0, 5'd0, 32'd0);
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                step();
                n++;
            end
        end
        check("drain_done", exp_q.size(), 0);
        step();

        // Reset with three live entries queued.
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 5'(24 + i), 32'hC000_0000 + 32'(i));
            set_b(1'b1, 5'(16 + i), 32'hD000_0000 + 32'(i));
            exp_wr(5'(24 + i), 32'hC000_0000 + 32'(i));
            step();
        end
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        check("prerst_mask", pending_mask, 32'h0007_0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_regwrite", RegWrite, 0);
        check("midrst_mask", pending_mask, 0);
        check("midrst_bready", b_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("postrst_quiet", RegWrite, 0);
        end

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
